// File: rtl/cp0_timer_ext.sv
// Coprocessor-0 for the pipelined MIPS core: Status/Cause/EPC/BadVAddr, Count/Compare timer,
// hardware interrupt sampling and committed-exception entry with EXL nesting.
module cp0_timer_ext #(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_BASE   = 32'h0000_0000,
    parameter logic [31:0] BOOT_BASE  = 32'hBFC0_0200,
    parameter logic [31:0] PRID       = 32'h0001_8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [4:0]            r_reg,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    input  logic [NUM_HW_INT-1:0] int_,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  eret,
    output logic [31:0]           STATUS_out,
    output logic [31:0]           CAUSE_out,
    output logic [31:0]           EPC_out,
    output logic                  INT,
    output logic [31:0]           exc_vector
);

    localparam logic [31:0] DIV_LAST = 32'(COUNT_DIV - 1);

    logic                  ie_q, ie_d;
    logic                  exl_q, exl_d;
    logic [7:0]            im_q, im_d;
    logic                  bev_q, bev_d;
    logic                  bd_q, bd_d;
    logic                  ti_q, ti_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic [4:0]            exccode_q, exccode_d;
    logic [NUM_HW_INT-1:0] int_q, int_d;
    logic [31:0]           epc_q, epc_d;
    logic [31:0]           badvaddr_q, badvaddr_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic [31:0]           presc_q, presc_d;

    logic [5:0]  int_pad_s;
    logic [7:0]  ip_s;
    logic        tick_s;
    logic [31:0] count_inc_s;
    logic        wr_status_s, wr_cause_s, wr_epc_s, wr_count_s, wr_compare_s;

    // Widen the sampled interrupt lines to the six Cause.IP[7:2] slots
    always_comb begin
        int_pad_s = 6'b000000;
        for (int k = 0; k < NUM_HW_INT; k++) begin
            int_pad_s[k] = int_q[k];
        end
        ip_s = {ti_q | int_pad_s[5], int_pad_s[4:0], ip_sw_q};
    end

    // Register views, mfc0 read mux, interrupt request and vector
    always_comb begin
        STATUS_out = {9'd0, bev_q, 6'd0, im_q, 6'd0, exl_q, ie_q};
        CAUSE_out  = {bd_q, ti_q, 14'd0, ip_s, 1'b0, exccode_q, 2'b00};
        EPC_out    = epc_q;
        INT        = (|(ip_s & im_q)) & ie_q & ~exl_q;
        exc_vector = (bev_q ? BOOT_BASE : EXC_BASE) + 32'h0000_0180;
        case (r_reg)
            5'd8:    data_out = badvaddr_q;
            5'd9:    data_out = count_q;
            5'd11:   data_out = compare_q;
            5'd12:   data_out = STATUS_out;
            5'd13:   data_out = CAUSE_out;
            5'd14:   data_out = epc_q;
            5'd15:   data_out = PRID;
            default: data_out = 32'd0;
        endcase
    end

    // Next-state: timer, then exception > eret > mtc0 for the control registers
    always_comb begin
        ie_d       = ie_q;
        exl_d      = exl_q;
        im_d       = im_q;
        bev_d      = bev_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        int_d      = int_;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        presc_d    = presc_q;

        wr_status_s  = we && (r_reg == 5'd12);
        wr_cause_s   = we && (r_reg == 5'd13);
        wr_epc_s     = we && (r_reg == 5'd14);
        wr_count_s   = we && (r_reg == 5'd9);
        wr_compare_s = we && (r_reg == 5'd11);
        tick_s       = (presc_q == DIV_LAST);
        count_inc_s  = count_q + 32'd1;

        if (wr_count_s) begin
            count_d = data_in;
            presc_d = 32'd0;
        end else if (tick_s) begin
            count_d = count_inc_s;
            presc_d = 32'd0;
        end else begin
            presc_d = presc_q + 32'd1;
        end

        // A Compare write clears TI even if the match lands on the same edge
        if (wr_compare_s) begin
            compare_d = data_in;
            ti_d      = 1'b0;
        end else if (tick_s && !wr_count_s && (count_inc_s == compare_q)) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end

        if (exc_valid) begin
            if (!exl_q) begin
                epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_bd;
            end else begin
                epc_d = epc_q;
                bd_d  = bd_q;
            end
            exccode_d = exc_code;
            exl_d     = 1'b1;
            if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
                badvaddr_d = exc_badvaddr;
            end else begin
                badvaddr_d = badvaddr_q;
            end
        end else if (eret) begin
            exl_d = 1'b0;
            if (wr_cause_s) begin
                ip_sw_d = data_in[9:8];
            end else begin
                ip_sw_d = ip_sw_q;
            end
            if (wr_epc_s) begin
                epc_d = data_in;
            end else begin
                epc_d = epc_q;
            end
        end else begin
            if (wr_status_s) begin
                ie_d  = data_in[0];
                exl_d = data_in[1];
                im_d  = data_in[15:8];
                bev_d = data_in[22];
            end else begin
                ie_d = ie_q;
            end
            if (wr_cause_s) begin
                ip_sw_d = data_in[9:8];
            end else begin
                ip_sw_d = ip_sw_q;
            end
            if (wr_epc_s) begin
                epc_d = data_in;
            end else begin
                epc_d = epc_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= 8'd0;
            bev_q      <= 1'b1;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= 2'b00;
            exccode_q  <= 5'd0;
            int_q      <= '0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            presc_q    <= 32'd0;
        end else begin
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            im_q       <= im_d;
            bev_q      <= bev_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            int_q      <= int_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            presc_q    <= presc_d;
        end
    end

endmodule

// File: tb/tb_cp0_timer_ext.sv
// Directed bench for cp0_timer_ext with default parameters (6 interrupt lines, COUNT_DIV=2).
module tb_cp0_timer_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  r_reg;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [5:0]  int_;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] status_out, cause_out, epc_out, exc_vector;
    logic        int_out;

    int n_checks = 0;
    int n_err    = 0;

    cp0_timer_ext dut (
        .clk(clk), .rst(rst), .we(we), .r_reg(r_reg), .data_in(data_in),
        .data_out(data_out), .int_(int_), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret(eret),
        .STATUS_out(status_out), .CAUSE_out(cause_out), .EPC_out(epc_out),
        .INT(int_out), .exc_vector(exc_vector)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] r, input logic [31:0] exp);
        r_reg = r;
        #1;
        check(tag, data_out, exp);
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        we = 1'b1; r_reg = r; data_in = d;
        tick();
        we = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd, input logic [31:0] bva);
        exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badvaddr = bva;
        tick();
        exc_valid = 1'b0; exc_bd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; r_reg = 5'd0; data_in = 32'd0; int_ = 6'd0;
        exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
        exc_badvaddr = 32'd0; eret = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset values
        rd("rst_status", 5'd12, 32'h0040_0000);
        rd("rst_cause", 5'd13, 32'h0000_0000);
        rd("rst_epc", 5'd14, 32'h0000_0000);
        rd("rst_prid", 5'd15, 32'h0001_8000);
        rd("rst_count", 5'd9, 32'h0000_0000);
        check("rst_int", {31'd0, int_out}, 32'd0);
        check("rst_vector", exc_vector, 32'hBFC0_0380);
        tick(); tick();
        rd("first_count_inc", 5'd9, 32'h0000_0001);
        rd("unimpl_reg10", 5'd10, 32'h0000_0000);

        // Hardware interrupt path and first exception
        mtc0(5'd12, 32'h0000_0401);
        check("status_wr", status_out, 32'h0000_0401);
        check("vector_bev0", exc_vector, 32'h0000_0180);
        int_ = 6'b000001;
        #1;
        check("int_before_edge", {31'd0, int_out}, 32'd0);
        tick();
        check("ip2_set", cause_out, 32'h0000_0400);
        check("int_rise", {31'd0, int_out}, 32'd1);
        int_ = 6'd0;
        exc(5'd0, 32'h0000_0100, 1'b0, 32'd0);
        check("exc0_epc", epc_out, 32'h0000_0100);
        check("exc0_status", status_out, 32'h0000_0403);
        check("exc0_int", {31'd0, int_out}, 32'd0);

        // Branch-delay EPC correction and nested exception
        eret = 1'b1; tick(); eret = 1'b0;
        check("eret1_status", status_out, 32'h0000_0401);
        exc(5'd8, 32'h0000_0204, 1'b1, 32'd0);
        check("bd_epc", epc_out, 32'h0000_0200);
        check("bd_cause", cause_out, 32'h8000_0020);
        exc(5'd12, 32'h0000_0300, 1'b0, 32'd0);
        check("nest_epc", epc_out, 32'h0000_0200);
        check("nest_cause", cause_out, 32'h8000_0030);
        eret = 1'b1; we = 1'b1; r_reg = 5'd12; data_in = 32'hFFFF_FFFF;
        tick();
        eret = 1'b0; we = 1'b0;
        check("eret_beats_mtc0", status_out, 32'h0000_0401);

        // Count/Compare timer
        mtc0(5'd11, 32'h0000_0005);
        mtc0(5'd9, 32'h0000_0003);
        rd("count_loaded", 5'd9, 32'h0000_0003);
        tick(); tick(); tick();
        rd("count_4", 5'd9, 32'h0000_0004);
        check("ti_not_yet", {31'd0, cause_out[30]}, 32'd0);
        tick();
        rd("count_5", 5'd9, 32'h0000_0005);
        check("ti_ip7", cause_out, 32'hC000_8030);
        check("ti_masked_int", {31'd0, int_out}, 32'd0);
        mtc0(5'd11, 32'h0000_0100);
        check("ti_cleared", cause_out, 32'h8000_0030);

        // Exception beats a same-cycle EPC write; BadVAddr capture
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_0400; exc_badvaddr = 32'hDEAD_0001;
        we = 1'b1; r_reg = 5'd14; data_in = 32'h0000_1234;
        tick();
        exc_valid = 1'b0; we = 1'b0;
        check("adel_epc", epc_out, 32'h0000_0400);
        rd("adel_badvaddr", 5'd8, 32'hDEAD_0001);
        check("adel_cause", cause_out, 32'h0000_0010);
        check("adel_status", status_out, 32'h0000_0403);
        eret = 1'b1; we = 1'b1; r_reg = 5'd8; data_in = 32'h0000_0000;
        tick();
        eret = 1'b0; we = 1'b0;
        rd("badvaddr_ro", 5'd8, 32'hDEAD_0001);
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_wr_mask", cause_out, 32'h0000_0310);
        mtc0(5'd13, 32'h0000_0000);

        // Count wrap without and with a Compare match at zero
        mtc0(5'd9, 32'hFFFF_FFFF);
        tick();
        rd("wrap_hold", 5'd9, 32'hFFFF_FFFF);
        tick();
        rd("wrap_zero", 5'd9, 32'h0000_0000);
        check("wrap_no_ti", {31'd0, cause_out[30]}, 32'd0);
        mtc0(5'd11, 32'h0000_0000);
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd("count_wr_wins", 5'd9, 32'hFFFF_FFFF);
        tick(); tick();
        rd("wrap2_zero", 5'd9, 32'h0000_0000);
        check("wrap_ti", {31'd0, cause_out[30]}, 32'd1);

        // Reset wins over a same-cycle exception
        rst = 1'b1; exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_0800;
        exc_badvaddr = 32'h1111_2222;
        tick();
        rst = 1'b0; exc_valid = 1'b0;
        check("rst2_status", status_out, 32'h0040_0000);
        check("rst2_cause", cause_out, 32'h0000_0000);
        check("rst2_epc", epc_out, 32'h0000_0000);
        rd("rst2_badvaddr", 5'd8, 32'h0000_0000);
        rd("rst2_count", 5'd9, 32'h0000_0000);
        rd("rst2_compare", 5'd11, 32'h0000_0000);
        check("rst2_vector", exc_vector, 32'hBFC0_0380);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_timer_ext.md
# cp0_timer_ext

Parametrised coprocessor-0 for the pipelined MIPS core. It extends the existing CP0 function with several additions:
- a configurable number of hardware interrupt lines;
- a Count/Compare timer interrupt;
- BadVAddr capture;
- a single committed-exception port with branch-delay EPC correction and nested-exception (EXL) handling.

It sits beside the ID/EXE stages. It is written by mtc0 and by the pipeline's exception-commit logic, and read by mfc0 and the PC-select logic.

## Interface
Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2]
- COUNT_DIV, 2, clk cycles per Count increment (>=1)
- EXC_BASE, 32'h0000_0000, exception base when Status.BEV=0
- BOOT_BASE, 32'hBFC0_0200, exception base when Status.BEV=1
- PRID, 32'h0001_8000, constant returned for register 15

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  mtc0 write strobe
- r_reg  in  5  CP0 register number for read and write
- data_in  in  32  mtc0 write data
- data_out  out  32  mfc0 read data, combinational
- int_  in  NUM_HW_INT  level-sensitive hardware interrupt requests
- exc_valid  in  1  pipeline commits an exception or interrupt this cycle
- exc_code  in  5  ExcCode: 0 int, 4 AdEL, 5 AdES, 8 Sys, 10 RI, 12 Ov
- exc_pc  in  32  PC of the faulting instruction
- exc_bd  in  1  faulting instruction is in a branch delay slot
- exc_badvaddr  in  32  faulting address (AdEL/AdES only)
- eret  in  1  eret commits this cycle
- STATUS_out, CAUSE_out, EPC_out  out  32 each  register contents
- INT  out  1  interrupt request to pipeline, combinational
- exc_vector  out  32  handler address: (BEV ? BOOT_BASE : EXC_BASE) + 0x180

## Operation
Implemented registers:
- 8 BadVAddr: read-only to mtc0.
- 9 Count: R/W.
- 11 Compare: R/W.
- 12 Status: IE[0], EXL[1], IM[15:8] and BEV[22] are writable; other bits read 0.
- 13 Cause: BD[31] read-only, TI[30] read-only, IP[9:8] software-writable, IP[15:10] read-only, ExcCode[6:2] read-only; other bits read 0.
- 14 EPC: R/W.
- 15 PRId: constant PRID.
- All other numbers read 0; writes to them are ignored.

Interrupts:
- IP[2+k] is a registered copy of int_[k], updated every cycle.
- IP bits above NUM_HW_INT+1 read 0, except IP[7] (see timer).

Timer:
- A prescaler counts 0..COUNT_DIV-1. Count increments (wraps 0xFFFFFFFF->0) when the prescaler reaches COUNT_DIV-1.
- TI is set in the cycle Count updates to a value equal to Compare.
- IP[7] = TI OR the registered int_[5] (the latter only when NUM_HW_INT=6).
- Writing Compare clears TI.
- Writing Count loads data_in and clears the prescaler.

INT = |(IP & IM) & IE & ~EXL.

Exception entry (exc_valid=1):
- If EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc; BD <= exc_bd.
- If EXL=1: EPC and BD are held.
- In both cases: ExcCode <= exc_code and EXL <= 1.
- If exc_code is 4 or 5: BadVAddr <= exc_badvaddr.

eret: EXL <= 0. EPC is unchanged.

Same-cycle priority: rst > exc_valid > eret > mtc0.
- When exc_valid is set, an mtc0 to Status, Cause, EPC or BadVAddr is discarded.
- When eret is set, an mtc0 to Status is discarded.
- mtc0 to Count or Compare always applies unless rst is set.
- An mtc0 to Count in the same cycle as an increment: the write wins.
- A Compare write in the same cycle as a TI set: the clear wins.

## Timing
- Reset values:
  - Status = 32'h0040_0000 (BEV=1)
  - Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0, prescaler = 0
  - INT = 0; exc_vector = BOOT_BASE+0x180
- data_out, INT and exc_vector are combinational from the registers.
- Register writes are visible on the cycle after the write edge. There is no write-to-read bypass.
- A change on int_ reaches IP after 1 edge. INT rises in the same cycle as that IP update.
- Count first increments COUNT_DIV cycles after reset release.
- A reset asserted mid-exception or mid-count returns every register to its reset value at the next edge.

## Test plan
- Reset, then read regs 12/13/14/15 → 0x00400000 / 0 / 0 / PRID; INT=0; exc_vector=0xBFC00380.
- mtc0 Status=0x0000_0401, drive int_[0]=1 → IP[2]=1 one edge later; INT=1 in that same cycle; exc_valid with code 0 and exc_pc=0x100 → EPC=0x100, EXL=1, INT=0.
- exc_valid with code 8, exc_pc=0x204, exc_bd=1 → EPC=0x200, BD=1, ExcCode=8. Then a second exception with code 12 → EPC stays 0x200, ExcCode=12. Then eret → EXL=0.
- COUNT_DIV=2, Compare=5, Count=3 → Count reaches 5 four cycles later; TI=1; IP[7]=1. mtc0 Compare → TI=0.
- Same cycle: exc_valid (code 4, badvaddr=0xDEAD0001) plus mtc0 EPC=0x1234 → EPC=exc_pc, BadVAddr=0xDEAD0001, mtc0 discarded.
- Count=0xFFFFFFFF → wraps to 0 after one increment with no TI unless Compare=0.
